rvh_ptw_l1d_walk_port: RTL and testbench

//  PTW-side initiator of the PTW<->L1D walk-request interface. Accepts PTE-fetch requests from the

---
 rtl/rvh_l1d_pkg.sv | 24 ++
 rtl/rvh_ptw_l1d_walk_slot.sv | 57 +++++
 rtl/rvh_ptw_l1d_walk_port.sv | 133 +++++++++++++
 tb/tb_rvh_ptw_l1d_walk_port.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// Shared types and widths for the PTW <-> L1D walk-request path.
package rvh_l1d_pkg;

  localparam int unsigned PTW_ID_WIDTH  = 1;
  localparam int unsigned PADDR_WIDTH   = 56;
  localparam int unsigned PTE_WIDTH     = 64;
  localparam int unsigned PTW_TAG_WIDTH = 4;

  typedef enum logic [2:0] {
    SLOT_FREE  = 3'd0,
    SLOT_ISSUE = 3'd1,
    SLOT_WAIT  = 3'd2,
    SLOT_DONE  = 3'd3,
    SLOT_DRAIN = 3'd4
  } ptw_slot_state_e;

  typedef struct packed {
    ptw_slot_state_e            state;
    logic [PADDR_WIDTH-1:0]     paddr;
    logic [PTW_TAG_WIDTH-1:0]   tag;
    logic [PTE_WIDTH-1:0]       pte;
  } ptw_walk_slot_t;

endpackage

// File: rtl/rvh_ptw_l1d_walk_slot.sv
// One tracked walk request: lifecycle FSM plus its paddr/tag/pte payload.
module rvh_ptw_l1d_walk_slot
  import rvh_l1d_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [PADDR_WIDTH-1:0]   alloc_paddr,
  input  logic [PTW_TAG_WIDTH-1:0] alloc_tag,
  input  logic                     issue_hs,
  input  logic                     resp,
  input  logic [PTE_WIDTH-1:0]     resp_pte,
  input  logic                     ret_hs,
  output ptw_walk_slot_t           slot
);

  // Slot state and payload; a flush sends slots with a walk in flight to DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot.state <= SLOT_FREE;
      slot.paddr <= '0;
      slot.tag   <= '0;
      slot.pte   <= '0;
    end else begin
      case (slot.state)
        SLOT_FREE: begin
          if (alloc) begin
            slot.state <= SLOT_ISSUE;
            slot.paddr <= alloc_paddr;
            slot.tag   <= alloc_tag;
          end
        end
        SLOT_ISSUE: begin
          if (flush)         slot.state <= issue_hs ? SLOT_DRAIN : SLOT_FREE;
          else if (issue_hs) slot.state <= SLOT_WAIT;
        end
        SLOT_WAIT: begin
          if (resp) begin
            slot.state <= flush ? SLOT_FREE : SLOT_DONE;
            slot.pte   <= resp_pte;
          end else if (flush) begin
            slot.state <= SLOT_DRAIN;
          end
        end
        SLOT_DONE: begin
          if (flush || ret_hs) slot.state <= SLOT_FREE;
        end
        SLOT_DRAIN: begin
          if (resp) slot.state <= SLOT_FREE;
        end
        default: slot.state <= SLOT_FREE;
      endcase
    end
  end

endmodule

// File: rtl/rvh_ptw_l1d_walk_port.sv
// PTW-side walk-request initiator: allocates walker requests to slots, issues them to
// L1D, and returns PTEs to the walkers. Slot index doubles as the L1D request id.
module rvh_ptw_l1d_walk_port
  import rvh_l1d_pkg::*;
#(
  parameter int unsigned NUM_SLOTS           = 2,
  parameter int unsigned L1D_MAX_OUTSTANDING = 1,
  parameter int unsigned TAG_WIDTH           = PTW_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    walker_req_vld_i,
  output logic                    walker_req_rdy_o,
  input  logic [PADDR_WIDTH-1:0]  walker_req_paddr_i,
  input  logic [TAG_WIDTH-1:0]    walker_req_tag_i,
  output logic                    ptw_walk_req_vld_o,
  input  logic                    ptw_walk_req_rdy_i,
  output logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_o,
  output logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_o,
  input  logic                    ptw_walk_resp_vld_i,
  output logic                    ptw_walk_resp_rdy_o,
  input  logic [PTW_ID_WIDTH-1:0] ptw_walk_resp_id_i,
  input  logic [PTE_WIDTH-1:0]    ptw_walk_resp_pte_i,
  output logic                    walker_resp_vld_o,
  input  logic                    walker_resp_rdy_i,
  output logic [TAG_WIDTH-1:0]    walker_resp_tag_o,
  output logic [PTE_WIDTH-1:0]    walker_resp_pte_o
);

  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

  ptw_walk_slot_t            slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]      free_vec;
  logic [NUM_SLOTS-1:0]      issue_vec;
  logic [NUM_SLOTS-1:0]      done_vec;
  logic [PTW_ID_WIDTH-1:0]   alloc_id;
  logic [PTW_ID_WIDTH-1:0]   issue_pri_id;
  logic [PTW_ID_WIDTH-1:0]   ret_pri_id;
  logic [PTW_ID_WIDTH-1:0]   issue_id;
  logic [PTW_ID_WIDTH-1:0]   ret_id;
  logic [PTW_ID_WIDTH-1:0]   issue_id_q;
  logic [PTW_ID_WIDTH-1:0]   ret_id_q;
  logic                      issue_lock_q;
  logic                      ret_lock_q;
  logic [CNT_W-1:0]          inflight_cnt;
  logic                      issue_hs;

  // Lowest-index priority encoders for alloc, issue and return.
  always_comb begin
    alloc_id     = '0;
    issue_pri_id = '0;
    ret_pri_id   = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (free_vec[i])  alloc_id     = PTW_ID_WIDTH'(i);
      if (issue_vec[i]) issue_pri_id = PTW_ID_WIDTH'(i);
      if (done_vec[i])  ret_pri_id   = PTW_ID_WIDTH'(i);
    end
  end

  // A presented-but-stalled slot stays selected even if a lower slot becomes eligible.
  assign issue_id = issue_lock_q ? issue_id_q : issue_pri_id;
  assign ret_id   = ret_lock_q   ? ret_id_q   : ret_pri_id;

  assign walker_req_rdy_o    = (|free_vec) & ~flush_i;
  assign ptw_walk_req_vld_o  = (|issue_vec) & (32'(inflight_cnt) < L1D_MAX_OUTSTANDING);
  assign ptw_walk_req_id_o   = issue_id;
  assign ptw_walk_req_addr_o = slot_q[issue_id].paddr;
  assign ptw_walk_resp_rdy_o = 1'b1;
  assign walker_resp_vld_o   = |done_vec;
  assign walker_resp_tag_o   = TAG_WIDTH'(slot_q[ret_id].tag);
  assign walker_resp_pte_o   = slot_q[ret_id].pte;
  assign issue_hs            = ptw_walk_req_vld_o & ptw_walk_req_rdy_i;

  // Per-slot trackers, each driven by its decoded share of the handshakes.
  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_slot
    assign free_vec[g]  = (slot_q[g].state == SLOT_FREE);
    assign issue_vec[g] = (slot_q[g].state == SLOT_ISSUE);
    assign done_vec[g]  = (slot_q[g].state == SLOT_DONE);

    rvh_ptw_l1d_walk_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush_i),
      .alloc       (walker_req_vld_i & walker_req_rdy_o & (alloc_id == PTW_ID_WIDTH'(g))),
      .alloc_paddr (walker_req_paddr_i),
      .alloc_tag   (PTW_TAG_WIDTH'(walker_req_tag_i)),
      .issue_hs    (issue_hs & (issue_id == PTW_ID_WIDTH'(g))),
      .resp        (ptw_walk_resp_vld_i & (ptw_walk_resp_id_i == PTW_ID_WIDTH'(g))),
      .resp_pte    (ptw_walk_resp_pte_i),
      .ret_hs      (walker_resp_vld_o & walker_resp_rdy_i & (ret_id == PTW_ID_WIDTH'(g))),
      .slot        (slot_q[g])
    );
  end

  // Selection locks and the count of walks L1D still owes a response for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_lock_q <= 1'b0;
      issue_id_q   <= '0;
      ret_lock_q   <= 1'b0;
      ret_id_q     <= '0;
      inflight_cnt <= '0;
    end else begin
      issue_lock_q <= ptw_walk_req_vld_o & ~ptw_walk_req_rdy_i & ~flush_i;
      issue_id_q   <= issue_id;
      ret_lock_q   <= walker_resp_vld_o & ~walker_resp_rdy_i & ~flush_i;
      ret_id_q     <= ret_id;
      case ({issue_hs, ptw_walk_resp_vld_i})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Protocol checks on L1D responses and the outstanding-walk limit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (ptw_walk_resp_vld_i) begin
        assert (32'(ptw_walk_resp_id_i) < NUM_SLOTS)
          else $error("walk resp id %0d out of range", ptw_walk_resp_id_i);
        assert (slot_q[ptw_walk_resp_id_i].state inside {SLOT_WAIT, SLOT_DRAIN})
          else $error("walk resp for slot %0d with no walk in flight", ptw_walk_resp_id_i);
      end
      assert (32'(inflight_cnt) <= L1D_MAX_OUTSTANDING)
        else $error("inflight_cnt %0d exceeds limit", inflight_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rvh_ptw_l1d_walk_port.sv
// Directed bench: vector table on a 1-outstanding instance, hand sequences for
// out-of-order return (2-outstanding instance) and mid-walk reset.
module tb_rvh_ptw_l1d_walk_port;
  import rvh_l1d_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Instance A: NUM_SLOTS=2, L1D_MAX_OUTSTANDING=1
  logic                    a_fl, a_rv, a_lrdy, a_pv, a_wrdy;
  logic [PADDR_WIDTH-1:0]  a_pa;
  logic [3:0]              a_tag;
  logic [PTW_ID_WIDTH-1:0] a_pid;
  logic [PTE_WIDTH-1:0]    a_pte;
  logic                    a_rdy, a_lv, a_prdy, a_wv;
  logic [PTW_ID_WIDTH-1:0] a_lid;
  logic [PADDR_WIDTH-1:0]  a_la;
  logic [3:0]              a_wt;
  logic [PTE_WIDTH-1:0]    a_wp;

  // Instance B: NUM_SLOTS=2, L1D_MAX_OUTSTANDING=2
  logic                    b_fl, b_rv, b_lrdy, b_pv, b_wrdy;
  logic [PADDR_WIDTH-1:0]  b_pa;
  logic [3:0]              b_tag;
  logic [PTW_ID_WIDTH-1:0] b_pid;
  logic [PTE_WIDTH-1:0]    b_pte;
  logic                    b_rdy, b_lv, b_prdy, b_wv;
  logic [PTW_ID_WIDTH-1:0] b_lid;
  logic [PADDR_WIDTH-1:0]  b_la;
  logic [3:0]              b_wt;
  logic [PTE_WIDTH-1:0]    b_wp;

  rvh_ptw_l1d_walk_port #(.NUM_SLOTS(2), .L1D_MAX_OUTSTANDING(1), .TAG_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(a_fl),
    .walker_req_vld_i(a_rv), .walker_req_rdy_o(a_rdy),
    .walker_req_paddr_i(a_pa), .walker_req_tag_i(a_tag),
    .ptw_walk_req_vld_o(a_lv), .ptw_walk_req_rdy_i(a_lrdy),
    .ptw_walk_req_id_o(a_lid), .ptw_walk_req_addr_o(a_la),
    .ptw_walk_resp_vld_i(a_pv), .ptw_walk_resp_rdy_o(a_prdy),
    .ptw_walk_resp_id_i(a_pid), .ptw_walk_resp_pte_i(a_pte),
    .walker_resp_vld_o(a_wv), .walker_resp_rdy_i(a_wrdy),
    .walker_resp_tag_o(a_wt), .walker_resp_pte_o(a_wp)
  );

  rvh_ptw_l1d_walk_port #(.NUM_SLOTS(2), .L1D_MAX_OUTSTANDING(2), .TAG_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(b_fl),
    .walker_req_vld_i(b_rv), .walker_req_rdy_o(b_rdy),
    .walker_req_paddr_i(b_pa), .walker_req_tag_i(b_tag),
    .ptw_walk_req_vld_o(b_lv), .ptw_walk_req_rdy_i(b_lrdy),
    .ptw_walk_req_id_o(b_lid), .ptw_walk_req_addr_o(b_la),
    .ptw_walk_resp_vld_i(b_pv), .ptw_walk_resp_rdy_o(b_prdy),
    .ptw_walk_resp_id_i(b_pid), .ptw_walk_resp_pte_i(b_pte),
    .walker_resp_vld_o(b_wv), .walker_resp_rdy_i(b_wrdy),
    .walker_resp_tag_o(b_wt), .walker_resp_pte_o(b_wp)
  );

  // Inputs for one cycle followed by the outputs expected in that same cycle.
  typedef struct {
    logic                    fl, rv;
    logic [PADDR_WIDTH-1:0]  pa;
    logic [3:0]              tag;
    logic                    lrdy, pv;
    logic [PTW_ID_WIDTH-1:0] pid;
    logic [PTE_WIDTH-1:0]    pte;
    logic                    wrdy;
    logic                    e_rdy, e_lv;
    logic [PTW_ID_WIDTH-1:0] e_lid;
    logic [PADDR_WIDTH-1:0]  e_la;
    logic                    e_wv;
    logic [3:0]              e_wt;
    logic [PTE_WIDTH-1:0]    e_wp;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got 'h%0h expected 'h%0h", name, idx, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_fl, a_rv, a_lrdy, a_pv, a_wrdy} = '0; a_pa = '0; a_tag = '0; a_pid = '0; a_pte = '0;
    {b_fl, b_rv, b_lrdy, b_pv, b_wrdy} = '0; b_pa = '0; b_tag = '0; b_pid = '0; b_pte = '0;

    // fields: fl rv pa tag lrdy pv pid pte wrdy | rdy lv lid la wv wt wp
    // single walk
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,1,'h8000_1000,3,1,0,0,'h0,0,  1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,          1,1,0,'h8000_1000,0,0,'h0});
    for (int i = 0; i < 4; i++)
      tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,        1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,1,0,'h2000_00CF,0,  1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,1,          1,0,0,'h0,1,3,'h2000_00CF});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,1,          1,0,0,'h0,0,0,'h0});
    // back-to-back requests, one outstanding, third refused
    tv.push_back(vec_t'{0,1,'h1000,1,0,0,0,'h0,0,       1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,1,'h2000,2,1,0,0,'h0,0,       1,1,0,'h1000,0,0,'h0});
    tv.push_back(vec_t'{0,1,'h3000,5,1,0,0,'h0,0,       0,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,1,0,'h11,0,         0,0,0,'h0,0,0,'h0});
    // backpressure on both sides
    for (int i = 0; i < 4; i++)
      tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,        0,1,1,'h2000,1,1,'h11});
    tv.push_back(vec_t'{0,1,'h5000,4,0,0,0,'h0,1,       0,1,1,'h2000,1,1,'h11});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,1,1,'h2000,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,          1,1,1,'h2000,0,0,'h0});
    // flush with slot1 in WAIT -> drain, response dropped
    tv.push_back(vec_t'{1,1,'h4000,6,0,0,0,'h0,0,       0,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,1,'h4000,6,0,0,0,'h0,0,       1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          0,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,1,1,'hDEAD,0,       0,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,1,0,'h4000,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,          1,1,0,'h4000,0,0,'h0});
    // flush of a DONE slot
    tv.push_back(vec_t'{0,0,'h0,0,0,1,0,'h55,0,         1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{1,0,'h0,0,0,0,0,'h0,0,          0,0,0,'h0,1,6,'h55});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,0,0,'h0,0,0,'h0});
    // response in the flush cycle frees the slot directly
    tv.push_back(vec_t'{0,1,'h7000,7,1,0,0,'h0,0,       1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,          1,1,0,'h7000,0,0,'h0});
    tv.push_back(vec_t'{1,0,'h0,0,0,1,0,'h77,0,         0,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,1,'h8000,8,1,0,0,'h0,0,       1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,          1,1,0,'h8000,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,1,0,'h88,0,         1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,1,          1,0,0,'h0,1,8,'h88});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,0,0,'h0,0,0,'h0});
    // flush during the issue handshake -> drain
    tv.push_back(vec_t'{0,1,'h9000,9,0,0,0,'h0,0,       1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{1,0,'h0,0,1,0,0,'h0,0,          0,1,0,'h9000,0,0,'h0});
    tv.push_back(vec_t'{0,1,'hA000,'hA,0,0,0,'h0,0,     1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,1,0,'h99,0,         0,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,1,0,0,'h0,0,          1,1,1,'hA000,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,1,1,'hAA,0,         1,0,0,'h0,0,0,'h0});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,1,          1,0,0,'h0,1,'hA,'hAA});
    tv.push_back(vec_t'{0,0,'h0,0,0,0,0,'h0,0,          1,0,0,'h0,0,0,'h0});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tv[k]) begin
      cyc();
      a_fl = tv[k].fl; a_rv = tv[k].rv; a_pa = tv[k].pa; a_tag = tv[k].tag;
      a_lrdy = tv[k].lrdy; a_pv = tv[k].pv; a_pid = tv[k].pid; a_pte = tv[k].pte;
      a_wrdy = tv[k].wrdy;
      #2;
      chk("req_rdy", k, 64'(a_rdy), 64'(tv[k].e_rdy));
      chk("l1d_vld", k, 64'(a_lv), 64'(tv[k].e_lv));
      if (tv[k].e_lv) begin
        chk("l1d_id", k, 64'(a_lid), 64'(tv[k].e_lid));
        chk("l1d_addr", k, 64'(a_la), 64'(tv[k].e_la));
      end
      chk("wresp_vld", k, 64'(a_wv), 64'(tv[k].e_wv));
      if (tv[k].e_wv) begin
        chk("wresp_tag", k, 64'(a_wt), 64'(tv[k].e_wt));
        chk("wresp_pte", k, 64'(a_wp), 64'(tv[k].e_wp));
      end
    end
    chk("resp_rdy", 0, 64'(a_prdy), 64'd1);
    cyc();
    {a_fl, a_rv, a_lrdy, a_pv, a_wrdy} = '0;

    // Out-of-order return on the 2-outstanding instance
    b_rv = 1; b_pa = 'h100; b_tag = 'hA; b_lrdy = 1;
    cyc();
    b_pa = 'h200; b_tag = 'hB; #1;
    chk("ooo_id0", 1, 64'({b_lv, b_lid}), 64'({1'b1, 1'b0}));
    chk("ooo_addr0", 1, 64'(b_la), 64'h100);
    cyc();
    b_rv = 0; #1;
    chk("ooo_id1", 2, 64'({b_lv, b_lid}), 64'({1'b1, 1'b1}));
    chk("ooo_addr1", 2, 64'(b_la), 64'h200);
    cyc();
    b_lrdy = 0; b_pv = 1; b_pid = 1; b_pte = 'hB1; #1;
    chk("ooo_lv_idle", 3, 64'(b_lv), 64'd0);
    cyc();
    b_pid = 0; b_pte = 'hA0; b_wrdy = 1; #1;
    chk("ooo_first_tag", 4, 64'({b_wv, b_wt}), 64'({1'b1, 4'hB}));
    chk("ooo_first_pte", 4, 64'(b_wp), 64'hB1);
    cyc();
    b_pv = 0; #1;
    chk("ooo_second_tag", 5, 64'({b_wv, b_wt}), 64'({1'b1, 4'hA}));
    chk("ooo_second_pte", 5, 64'(b_wp), 64'hA0);
    cyc();
    b_wrdy = 0; #1;
    chk("ooo_drained", 6, 64'({b_wv, b_rdy}), 64'({1'b0, 1'b1}));

    // Asynchronous reset while a walk is in WAIT and another is queued
    cyc();
    a_rv = 1; a_pa = 'hC000; a_tag = 'hC; a_lrdy = 1;
    cyc();
    a_pa = 'hD000; a_tag = 'hD;
    cyc();
    a_rv = 0; a_lrdy = 0; #1;
    chk("pre_rst_rdy", 0, 64'(a_rdy), 64'd0);
    rst_n = 1'b0; #1;
    chk("rst_rdy", 0, 64'(a_rdy), 64'd1);
    chk("rst_l1d_vld", 0, 64'(a_lv), 64'd0);
    chk("rst_wresp_vld", 0, 64'(a_wv), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rdy", 0, 64'({a_rdy, a_lv, a_wv}), 64'({1'b1, 1'b0, 1'b0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
